// File: rtl/noc_local_rx_checker.sv
// noc_local_rx_checker: ejection-port flit buffer plus framing/destination/sequence checker.
// Optional feature: define NOC_RX_SEQ_CHECK_EN to enable payload sequence checking (err_seq).

// Generic single-clock FIFO, registered occupancy.
// Latency: a pushed entry is poppable from the next cycle; no bypass path.
// Backpressure: in_rdy = !full from the count register only; full never accepts, even while popping.
module noc_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    assign in_rdy  = (cnt != (AW+1)'(DEPTH));
    assign out_vld = (cnt != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Local ejection checker: FIFO then framing FSM, dest/sequence checks, counters, sticky flags.
// Latency: flit accepted in cycle N is checked at end of N+1, results visible from N+2.
// Backpressure: in_ready = !fifo_full; sink_stall holds the FIFO head so the router sees backpressure.
module noc_local_rx_checker #(
    parameter int             X_W       = 4,
    parameter int             Y_W       = 4,
    parameter logic [X_W-1:0] X_ID      = '0,
    parameter logic [Y_W-1:0] Y_ID      = '0,
    parameter int             PAYLOAD_W = 16,
    parameter int             DEPTH     = 4,
    localparam int            FLIT_W    = 2 + 2*X_W + 2*Y_W + PAYLOAD_W
) (
    input  logic                 noc_clk,
    input  logic                 noc_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLIT_W-1:0]    in_flit,
    input  logic                 sink_stall,
    input  logic                 clear_stats,
    output logic [15:0]          pkt_count,
    output logic [15:0]          flit_count,
    output logic                 err_frame,
    output logic                 err_dest,
    output logic                 err_seq,
    output logic [X_W+Y_W-1:0]   last_src
);
    typedef struct packed {
        logic [1:0]           typ;
        logic [X_W-1:0]       dst_x;
        logic [Y_W-1:0]       dst_y;
        logic [X_W-1:0]       src_x;
        logic [Y_W-1:0]       src_y;
        logic [PAYLOAD_W-1:0] payload;
    } hdr_t;

    localparam logic [1:0] TYPE_BODY      = 2'b00;
    localparam logic [1:0] TYPE_TAIL      = 2'b01;
    localparam logic [1:0] TYPE_HEAD      = 2'b10;
    localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

    typedef enum logic {ST_IDLE, ST_BODY} state_t;

    state_t state;
    state_t state_nxt;
    hdr_t   cur;
    logic   fifo_vld;
    logic   pop;
    logic   is_head;
    logic   pkt_inc;
    logic   frame_set;
    logic   dest_set;

    noc_rx_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (noc_clk),
        .rst_n   (noc_rst_n),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  (in_flit),
        .out_vld (fifo_vld),
        .out_rdy (!sink_stall),
        .out_dat (cur)
    );

    assign pop      = fifo_vld && !sink_stall;
    assign is_head  = pop && cur.typ[1];
    assign dest_set = is_head && ({cur.dst_x, cur.dst_y} != {X_ID, Y_ID});

    always_comb begin
        state_nxt = state;
        pkt_inc   = 1'b0;
        frame_set = 1'b0;
        if (pop) begin
            case (state)
                ST_IDLE: begin
                    case (cur.typ)
                        TYPE_HEAD:      state_nxt = ST_BODY;
                        TYPE_HEAD_TAIL: pkt_inc   = 1'b1;
                        default:        frame_set = 1'b1;
                    endcase
                end
                ST_BODY: begin
                    case (cur.typ)
                        TYPE_BODY: state_nxt = ST_BODY;
                        TYPE_TAIL: begin
                            state_nxt = ST_IDLE;
                            pkt_inc   = 1'b1;
                        end
                        // A head inside a packet restarts it rather than dropping it.
                        TYPE_HEAD: frame_set = 1'b1;
                        default: begin
                            frame_set = 1'b1;
                            pkt_inc   = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    endcase
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state      <= ST_IDLE;
            pkt_count  <= '0;
            flit_count <= '0;
            err_frame  <= 1'b0;
            err_dest   <= 1'b0;
            last_src   <= '0;
        end else begin
            state <= state_nxt;
            if (is_head) begin
                last_src <= {cur.src_x, cur.src_y};
            end
            // Clear outranks any same-cycle increment or flag set.
            if (clear_stats) begin
                pkt_count  <= '0;
                flit_count <= '0;
                err_frame  <= 1'b0;
                err_dest   <= 1'b0;
            end else begin
                if (pkt_inc && pkt_count != 16'hFFFF)   pkt_count  <= pkt_count + 16'd1;
                if (pop && flit_count != 16'hFFFF)      flit_count <= flit_count + 16'd1;
                if (frame_set) err_frame <= 1'b1;
                if (dest_set)  err_dest  <= 1'b1;
            end
        end
    end

`ifdef NOC_RX_SEQ_CHECK_EN
    logic [PAYLOAD_W-1:0] exp_pl;
    logic                 body_pop;

    assign body_pop = pop && (state == ST_BODY) && !cur.typ[1];

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            exp_pl  <= '0;
            err_seq <= 1'b0;
        end else begin
            // Always reload from the received payload so one bad flit flags once, then resyncs.
            if (is_head || body_pop) begin
                exp_pl <= cur.payload + (PAYLOAD_W)'(1);
            end
            if (clear_stats) begin
                err_seq <= 1'b0;
            end else if (body_pop && cur.payload != exp_pl) begin
                err_seq <= 1'b1;
            end
        end
    end
`else
    logic unused_payload;
    assign unused_payload = ^cur.payload;
    assign err_seq        = 1'b0;
`endif
endmodule

// File: tb/tb_noc_local_rx_checker.sv
// Randomised bench for noc_local_rx_checker against a packet-level reference model.
module tb_noc_local_rx_checker;
    localparam int XW  = 4;
    localparam int YW  = 4;
    localparam int PW  = 16;
    localparam int DEP = 4;
    localparam int FW  = 2 + 2*XW + 2*YW + PW;
    localparam logic [3:0] XI = 4'd3;
    localparam logic [3:0] YI = 4'd5;
`ifdef NOC_RX_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic          noc_clk = 1'b0;
    logic          noc_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_flit = '0;
    logic          sink_stall = 1'b0;
    logic          clear_stats = 1'b0;
    logic [15:0]   pkt_count;
    logic [15:0]   flit_count;
    logic          err_frame;
    logic          err_dest;
    logic          err_seq;
    logic [7:0]    last_src;

    int checks = 0;
    int failures = 0;

    // Reference model: packet-level view of the accepted flit stream.
    bit          m_open;
    logic [15:0] m_exp;
    logic [15:0] m_pkt;
    logic [15:0] m_flit;
    bit          m_ef, m_ed, m_es;
    logic [7:0]  m_src;

    noc_local_rx_checker #(
        .X_W(XW), .Y_W(YW), .X_ID(XI), .Y_ID(YI), .PAYLOAD_W(PW), .DEPTH(DEP)
    ) dut (
        .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .sink_stall(sink_stall), .clear_stats(clear_stats),
        .pkt_count(pkt_count), .flit_count(flit_count), .err_frame(err_frame),
        .err_dest(err_dest), .err_seq(err_seq), .last_src(last_src)
    );

    always #5 noc_clk = ~noc_clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [3:0] sx, input logic [3:0] sy, input logic [15:0] pl);
        return {t, dx, dy, sx, sy, pl};
    endfunction

    function void m_reset();
        m_open = 0; m_exp = 0; m_pkt = 0; m_flit = 0;
        m_ef = 0; m_ed = 0; m_es = 0; m_src = 0;
    endfunction

    function void m_clear();
        m_pkt = 0; m_flit = 0; m_ef = 0; m_ed = 0; m_es = 0;
    endfunction

    function void m_apply(input logic [FW-1:0] f);
        logic [1:0]  t;
        logic [15:0] pl;
        t  = f[FW-1:FW-2];
        pl = f[15:0];
        if (m_flit != 16'hFFFF) m_flit = m_flit + 1;
        if (t == T_HEAD || t == T_HT) begin
            if (f[FW-3:FW-10] != {XI, YI}) m_ed = 1;
            if (m_open) m_ef = 1;
            m_src = f[23:16];
            m_exp = pl + 16'd1;
            if (t == T_HT) begin
                if (m_pkt != 16'hFFFF) m_pkt = m_pkt + 1;
                m_open = 0;
            end else begin
                m_open = 1;
            end
        end else if (!m_open) begin
            m_ef = 1;
        end else begin
            if (SEQ && pl != m_exp) m_es = 1;
            m_exp = pl + 16'd1;
            if (t == T_TAIL) begin
                if (m_pkt != 16'hFFFF) m_pkt = m_pkt + 1;
                m_open = 0;
            end
        end
    endfunction

    task automatic send(input logic [FW-1:0] f, input bit rnd);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_flit  = f;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (rnd) sink_stall = ($urandom_range(0, 2) == 0);
            acc = in_ready;
            @(posedge noc_clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            m_apply(f);
        end else begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic drain();
        sink_stall = 1'b0;
        in_valid   = 1'b0;
        repeat (DEP + 3) @(posedge noc_clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        @(posedge noc_clk);
        #1;
        clear_stats = 1'b0;
        m_clear();
    endtask

    task automatic test_reset();
        noc_rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++;
        if ({pkt_count, flit_count, err_frame, err_dest, err_seq, last_src} !== 43'd0) begin
            failures++;
            $display("FAIL reset_state pkt=%0d flit=%0d ef=%0b ed=%0b es=%0b src=%h exp=all zero",
                     pkt_count, flit_count, err_frame, err_dest, err_seq, last_src);
        end
    endtask

    task automatic test_basic_packet();
        send(mk(T_HEAD, XI, YI, 4'd1, 4'd2, 16'd5), 0);
        send(mk(T_BODY, XI, YI, 4'd1, 4'd2, 16'd6), 0);
        send(mk(T_BODY, XI, YI, 4'd1, 4'd2, 16'd7), 0);
        send(mk(T_TAIL, XI, YI, 4'd1, 4'd2, 16'd8), 0);
        drain();
        checks++;
        if (pkt_count !== 16'd1 || flit_count !== 16'd4) begin
            failures++; $display("FAIL basic_counts pkt=%0d flit=%0d exp pkt=1 flit=4", pkt_count, flit_count);
        end
        checks++;
        if ({err_frame, err_dest, err_seq} !== 3'b000) begin
            failures++; $display("FAIL basic_errors got=%b exp=000", {err_frame, err_dest, err_seq});
        end
        checks++;
        if (last_src !== 8'h12) begin failures++; $display("FAIL basic_last_src got=%h exp=12", last_src); end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] fl [6];
        int idx;
        bit acc;
        for (int i = 0; i < 6; i++)
            fl[i] = mk(i == 0 ? T_HEAD : (i == 5 ? T_TAIL : T_BODY), XI, YI, 4'd7, 4'd9, 16'(100 + i));
        pulse_clear();
        sink_stall = 1'b1;
        in_valid = 1'b1;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_flit = fl[idx];
            acc = in_ready;
            @(posedge noc_clk);
            #1;
            if (acc) begin
                m_apply(fl[idx]);
                idx++;
                if (idx == DEP) begin
                    checks++;
                    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_fall got=%0b exp=0", in_ready); end
                end
            end
        end
        checks++;
        if (idx != DEP || in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_accepts got=%0d ready=%0b exp=%0d ready=0", idx, in_ready, DEP);
        end
        checks++;
        if (flit_count !== 16'd0) begin failures++; $display("FAIL bp_stalled_count got=%0d exp=0", flit_count); end
        sink_stall = 1'b0;
        @(posedge noc_clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_rise got=%0b exp=1", in_ready); end
        in_valid = 1'b0;
        send(fl[4], 0);
        send(fl[5], 0);
        drain();
        checks++;
        if (flit_count !== 16'd6 || pkt_count !== 16'd1 || {err_frame, err_dest, err_seq} !== 3'b000) begin
            failures++;
            $display("FAIL bp_release flit=%0d pkt=%0d err=%b exp flit=6 pkt=1 err=000",
                     flit_count, pkt_count, {err_frame, err_dest, err_seq});
        end
    endtask

    task automatic test_frame_and_clear();
        logic [15:0] pkt_before;
        pkt_before = pkt_count;
        send(mk(T_BODY, XI, YI, 4'd2, 4'd2, 16'd0), 0);
        drain();
        checks++;
        if (err_frame !== 1'b1 || pkt_count !== pkt_before) begin
            failures++; $display("FAIL frame_body_idle ef=%0b pkt=%0d exp ef=1 pkt=%0d", err_frame, pkt_count, pkt_before);
        end
        pulse_clear();
        checks++;
        if ({pkt_count, flit_count, err_frame, err_dest, err_seq} !== 35'd0) begin
            failures++; $display("FAIL clear_all pkt=%0d flit=%0d err=%b exp all zero",
                                 pkt_count, flit_count, {err_frame, err_dest, err_seq});
        end
        // Pop and clear land on the same edge: the clear must win.
        sink_stall = 1'b1;
        send(mk(T_HT, XI, YI, 4'd6, 4'd1, 16'd9), 0);
        sink_stall = 1'b0;
        clear_stats = 1'b1;
        @(posedge noc_clk);
        #1;
        clear_stats = 1'b0;
        m_clear();
        checks++;
        if (flit_count !== 16'd0 || pkt_count !== 16'd0 || last_src !== 8'h61) begin
            failures++; $display("FAIL clear_wins flit=%0d pkt=%0d src=%h exp 0 0 61", flit_count, pkt_count, last_src);
        end
    endtask

    task automatic test_dest_seq();
        send(mk(T_HEAD, XI + 4'd1, YI, 4'd0, 4'd0, 16'd0), 0);
        send(mk(T_TAIL, XI + 4'd1, YI, 4'd0, 4'd0, 16'd1), 0);
        drain();
        checks++;
        if (err_dest !== 1'b1 || err_frame !== 1'b0) begin
            failures++; $display("FAIL dest_mismatch ed=%0b ef=%0b exp ed=1 ef=0", err_dest, err_frame);
        end
        pulse_clear();
        send(mk(T_HEAD, XI, YI, 4'd1, 4'd1, 16'd3), 0);
        send(mk(T_BODY, XI, YI, 4'd1, 4'd1, 16'd5), 0);
        drain();
        checks++;
        if (err_seq !== SEQ) begin failures++; $display("FAIL seq_gap got=%0b exp=%0b", err_seq, SEQ); end
        pulse_clear();
        send(mk(T_TAIL, XI, YI, 4'd1, 4'd1, 16'd6), 0);
        drain();
        checks++;
        if (err_seq !== 1'b0 || pkt_count !== 16'd1) begin
            failures++; $display("FAIL seq_resync es=%0b pkt=%0d exp es=0 pkt=1", err_seq, pkt_count);
        end
        pulse_clear();
        send(mk(T_HEAD, XI, YI, 4'd2, 4'd3, 16'hFFFF), 0);
        send(mk(T_TAIL, XI, YI, 4'd2, 4'd3, 16'h0000), 0);
        drain();
        checks++;
        if ({err_frame, err_dest, err_seq} !== 3'b000 || pkt_count !== 16'd1) begin
            failures++; $display("FAIL seq_wrap err=%b pkt=%0d exp err=000 pkt=1", {err_frame, err_dest, err_seq}, pkt_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        send(mk(T_HEAD, XI, YI, 4'd4, 4'd4, 16'd20), 0);
        send(mk(T_BODY, XI, YI, 4'd4, 4'd4, 16'd21), 0);
        drain();
        @(posedge noc_clk);
        #3;
        noc_rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (flit_count !== 16'd0 || last_src !== 8'h00) begin
            failures++; $display("FAIL async_reset flit=%0d src=%h exp 0 00", flit_count, last_src);
        end
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        #1;
        send(mk(T_TAIL, XI, YI, 4'd4, 4'd4, 16'd22), 0);
        drain();
        checks++;
        if (err_frame !== 1'b1 || pkt_count !== 16'd0 || flit_count !== 16'd1) begin
            failures++; $display("FAIL reset_mid_pkt ef=%0b pkt=%0d flit=%0d exp ef=1 pkt=0 flit=1",
                                 err_frame, pkt_count, flit_count);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 120; n++) begin
                int sel;
                logic [1:0]  t;
                logic [3:0]  dx;
                logic [15:0] pl;
                sel = $urandom_range(0, 99);
                if (m_open) t = (sel < 60) ? T_BODY : (sel < 90) ? T_TAIL : (sel < 95) ? T_HEAD : T_HT;
                else        t = (sel < 50) ? T_HEAD : (sel < 90) ? T_HT : (sel < 95) ? T_BODY : T_TAIL;
                dx = ($urandom_range(0, 9) == 0) ? 4'($urandom) : XI;
                pl = ($urandom_range(0, 9) < 8) ? m_exp : 16'($urandom);
                send(mk(t, dx, YI, 4'($urandom), 4'($urandom), pl), 1);
            end
            drain();
            checks++;
            if ({pkt_count, flit_count, err_frame, err_dest, err_seq, last_src} !==
                {m_pkt, m_flit, m_ef, m_ed, m_es, m_src}) begin
                failures++;
                $display("FAIL random_round%0d got pkt=%0d flit=%0d err=%b src=%h exp pkt=%0d flit=%0d err=%b src=%h",
                         r, pkt_count, flit_count, {err_frame, err_dest, err_seq}, last_src,
                         m_pkt, m_flit, {m_ef, m_ed, m_es}, m_src);
            end
            pulse_clear();
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_backpressure();
        test_frame_and_clear();
        test_dest_seq();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/noc_local_rx_checker.md
# noc_local_rx_checker

Receive-side stage attached to a test node's local ejection path: accepts flits leaving the router's local output port, buffers them in a small FIFO, and checks packet framing, destination ID and payload sequence. It keeps packet/flit counters and sticky error flags so NoC traffic benches can self-check without a scoreboard. The `sink_stall` input models a slow consumer, which exercises router backpressure.

## Interface
- `X_ID`, 0, node X coordinate, `X_W` bits
- `Y_ID`, 0, node Y coordinate, `Y_W` bits
- `X_W`, 4, X coordinate width
- `Y_W`, 4, Y coordinate width
- `PAYLOAD_W`, 16, payload width
- `DEPTH`, 4, FIFO depth; power of two, ≥2
- `FLIT_W`, derived: 2+2·`X_W`+2·`Y_W`+`PAYLOAD_W` (34 with defaults)

Ports:
- `noc_clk`  in  1  single clock; all logic is rising-edge
- `noc_rst_n`  in  1  reset; asynchronous, active-low
- `in_valid`  in  1  flit valid
- `in_ready`  out  1  flit accepted when `in_valid`&&`in_ready`
- `in_flit`  in  `FLIT_W`  flit, MSB→LSB: type[1:0], dst_x, dst_y, src_x, src_y, payload
- `sink_stall`  in  1  when high, the FIFO is not popped
- `clear_stats`  in  1  synchronous clear of counters and error flags
- `pkt_count`  out  16  completed packets, saturating
- `flit_count`  out  16  checked flits, saturating
- `err_frame`  out  1  sticky framing error
- `err_dest`  out  1  sticky destination mismatch
- `err_seq`  out  1  sticky sequence error
- `last_src`  out  `X_W`+`Y_W`  {src_x,src_y} of the most recent head

## Operation
- Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEAD_TAIL=2'b11.
- FIFO:
  - `in_ready` = !full. There is no bypass: a full FIFO never accepts a flit, even while popping.
  - Pop when !empty && !`sink_stall`. Each popped flit enters the checker.
- FSM states IDLE and BODY; reset state is IDLE.
  - IDLE, HEAD → BODY.
  - IDLE, HEAD_TAIL → IDLE; `pkt_count`+1.
  - IDLE, BODY or TAIL → `err_frame`=1; flit is counted but otherwise ignored; stay in IDLE.
  - BODY, BODY → BODY.
  - BODY, TAIL → IDLE; `pkt_count`+1.
  - BODY, HEAD → `err_frame`=1; treated as the start of a new packet; stay in BODY.
  - BODY, HEAD_TAIL → `err_frame`=1; `pkt_count`+1; go to IDLE.
- Every head (HEAD or HEAD_TAIL):
  - Compare {dst_x,dst_y} with {`X_ID`,`Y_ID`}; mismatch → `err_dest`=1.
  - Load `last_src`.
  - Set expected = payload+1, mod 2^`PAYLOAD_W`.
- Non-head flit accepted in BODY state:
  - payload ≠ expected → `err_seq`=1.
  - In both cases, expected = received payload+1, so the check resyncs after an error.
- `flit_count`+1 on every popped flit.
- Both counters saturate at 16'hFFFF.
- `clear_stats`:
  - Zeroes both counters and all three error flags.
  - Does not touch the FIFO, FSM, expected value or `last_src`.
  - Clear wins over an increment or error set in the same cycle.
- Reset (asynchronous, at any time, including mid-packet):
  - FIFO emptied; `in_ready`=1 from the first clock after release.
  - FSM to IDLE; counters, flags and `last_src` to 0.
  - A packet in flight is lost; the next flit must be a head or it is flagged.

## Timing
- Flit accepted in cycle N is popped no earlier than N+1.
- Counters, flags, `last_src` and FSM state update at the end of the pop cycle and are visible from N+2 when there is no stall.
- Sustained throughput is 1 flit/cycle when `sink_stall`=0.
- With `sink_stall`=1 and input streaming, `in_ready` falls in the cycle after the DEPTH-th accept.
- `in_ready` rises in the cycle after the first pop from a full FIFO.
- `in_ready` is combinational from the FIFO occupancy register only; there is no path from `in_valid`.

## Configuration
- `NOC_RX_SEQ_CHECK_EN` defined: sequence checking as described.
- `NOC_RX_SEQ_CHECK_EN` undefined:
  - The expected-value register and comparator are removed; `err_seq` is tied to 0.
  - Framing, destination checks and counters are unchanged.

## Test plan
- Reset, then HEAD(dst=X_ID,Y_ID, payload 5), BODY 6, BODY 7, TAIL 8 → `pkt_count`=1, `flit_count`=4, all errors 0, `last_src` = head's src.
- `sink_stall`=1 with 6 flits offered back-to-back, DEPTH=4 → exactly 4 accepted, `in_ready`=0; release stall → all 6 flits checked in order, `flit_count`=6.
- BODY flit in IDLE → `err_frame`=1, `pkt_count` unchanged; `clear_stats` → all errors and counters 0 next cycle.
- HEAD with dst=(X_ID+1,Y_ID) → `err_dest`=1. Sequence HEAD 3, BODY 5, TAIL 6 → `err_seq`=1 (5≠4), no further error on 6; without `NOC_RX_SEQ_CHECK_EN`, `err_seq` stays 0.
- Reset asserted after HEAD+BODY, then TAIL sent → `err_frame`=1 and `pkt_count`=0. Also: HEAD payload 16'hFFFF, TAIL 16'h0000 → no `err_seq` (wrap-around).
